// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer.
package reaction_pkg;

  localparam int unsigned BCD_DIGIT_W   = 4;
  localparam int unsigned BCD_DIGITS    = 3;
  localparam int unsigned BCD_W         = BCD_DIGIT_W * BCD_DIGITS;
  localparam int unsigned CNT_W         = 9;
  localparam int unsigned LFSR_W        = 8;
  localparam int unsigned DEF_MIN_DELAY = 100;
  localparam logic [LFSR_W-1:0] DEF_LFSR_SEED = 8'hA5;

  // Largest digit value before a decimal carry.
  localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DELAY   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_RESULT  = 3'd3,
    ST_FOUL    = 3'd4
  } state_e;

  // Fibonacci LFSR step for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit BCD up-counter with synchronous clear and a terminal-count flag.
module bcd_counter3
  import reaction_pkg::*;
(
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             max_c_o
);

  logic [BCD_DIGIT_W-1:0] units_q, units_d;
  logic [BCD_DIGIT_W-1:0] tens_q,  tens_d;
  logic [BCD_DIGIT_W-1:0] hund_q,  hund_d;
  logic                   at_max;

  assign at_max = (units_q == BCD_NINE) && (tens_q == BCD_NINE) && (hund_q == BCD_NINE);

  // Next digit values: clear wins, increment ripples decimal carries, 999 holds.
  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    if (clr_i) begin
      units_d = '0;
      tens_d  = '0;
      hund_d  = '0;
    end else if (inc_i && !at_max) begin
      if (units_q == BCD_NINE) begin
        units_d = '0;
        if (tens_q == BCD_NINE) begin
          tens_d = '0;
          hund_d = hund_q + BCD_DIGIT_W'(1);
        end else begin
          tens_d = tens_q + BCD_DIGIT_W'(1);
        end
      end else begin
        units_d = units_q + BCD_DIGIT_W'(1);
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk_i) begin
    units_q <= units_d;
    tens_q  <= tens_d;
    hund_q  <= hund_d;
  end

  assign bcd_o   = {hund_q, tens_q, units_q};
  assign max_c_o = at_max;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: random hold-off, then counts 10 ms ticks until the react button.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = DEF_LFSR_SEED,
  parameter int unsigned       MIN_DELAY = DEF_MIN_DELAY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             start,
  input  logic             react,
  output logic             led_go,
  output logic             busy,
  output logic [BCD_W-1:0] bcd,
  output logic             done,
  output logic             false_start,
  output logic             overflow
);

  // Synchronizer and edge-detect flops.
  logic div_s1_q, div_s2_q, div_s3_q;
  logic start_s1_q, start_s2_q, start_s3_q;
  logic react_s1_q, react_s2_q;

  logic tick;
  logic start_p;
  logic react_s;

  logic [LFSR_W-1:0] lfsr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_e            state_q, state_d;

  // Control strobes from the next-state logic.
  logic clr_go;
  logic bcd_inc;
  logic sat_hit;
  logic bcd_max;

  logic led_go_q, led_go_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic false_start_q, false_start_d;
  logic overflow_q, overflow_d;

  // Bring the asynchronous inputs into the clk domain; keep a third flop for edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_s1_q   <= 1'b0;
      div_s2_q   <= 1'b0;
      div_s3_q   <= 1'b0;
      start_s1_q <= 1'b0;
      start_s2_q <= 1'b0;
      start_s3_q <= 1'b0;
      react_s1_q <= 1'b0;
      react_s2_q <= 1'b0;
    end else begin
      div_s1_q   <= div_clk;
      div_s2_q   <= div_s1_q;
      div_s3_q   <= div_s2_q;
      start_s1_q <= start;
      start_s2_q <= start_s1_q;
      start_s3_q <= start_s2_q;
      react_s1_q <= react;
      react_s2_q <= react_s1_q;
    end
  end

  assign tick    = div_s2_q & ~div_s3_q;
  assign start_p = start_s2_q & ~start_s3_q;
  assign react_s = react_s2_q;

  // Free-running delay source; a nonzero seed keeps it off the all-zero lockup state.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Hold-off tick counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Next state, counter load/decrement and BCD counter strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_go  = 1'b0;
    bcd_inc = 1'b0;
    sat_hit = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESULT, ST_FOUL: begin
        if (start_p) begin
          state_d = ST_DELAY;
          cnt_d   = CNT_W'(MIN_DELAY) + CNT_W'(lfsr_q);
          clr_go  = 1'b1;
        end
      end
      ST_DELAY: begin
        // A press before the lamp is a foul, even if a tick lands in the same cycle.
        if (react_s) begin
          state_d = ST_FOUL;
        end else if (tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_MEASURE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_MEASURE: begin
        // React beats a coincident tick so the reported time is not inflated.
        if (react_s) begin
          state_d = ST_RESULT;
        end else if (tick) begin
          if (bcd_max) begin
            state_d = ST_RESULT;
            sat_hit = 1'b1;
          end else begin
            bcd_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs track it exactly.
  always_comb begin
    led_go_d      = (state_d == ST_MEASURE);
    busy_d        = (state_d == ST_DELAY) || (state_d == ST_MEASURE);
    done_d        = (state_d == ST_RESULT);
    false_start_d = (state_d == ST_FOUL);
    overflow_d    = (state_d == ST_RESULT) &&
                    (sat_hit || ((state_q == ST_RESULT) && overflow_q));
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_go_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      false_start_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      led_go_q      <= led_go_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      false_start_q <= false_start_d;
      overflow_q    <= overflow_d;
    end
  end

  bcd_counter3 u_bcd (
    .clk_i   (clk),
    .clr_i   (rst | clr_go),
    .inc_i   (bcd_inc),
    .bcd_o   (bcd),
    .max_c_o (bcd_max)
  );

  assign led_go      = led_go_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign false_start = false_start_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter LFSR_SEED, default 8'hA5, nonzero reset value of the delay LFSR.
REQ-002 Parameter MIN_DELAY, default 100, minimum random wait in ticks (10 ms units).
REQ-003 clk  input  1  system clock (100 MHz); single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 div_clk  input  1  divided square wave from the clock divider (cout); each rising edge is one 10 ms tick.
REQ-006 start  input  1  asynchronous start button level, already debounced.
REQ-007 react  input  1  asynchronous reaction button level, already debounced.
REQ-008 led_go  output  1  go-lamp; high while measuring.
REQ-009 busy  output  1  high in DELAY or MEASURE.
REQ-010 bcd  output  12  three BCD digits {hundreds, tens, units} of reaction time in ticks.
REQ-011 done  output  1  high while a valid result is held.
REQ-012 false_start  output  1  high while a foul is held.
REQ-013 overflow  output  1  high when a result saturated at 999.

Function
REQ-014 div_clk, start and react each pass a 2-flop synchronizer; div_clk and start additionally get a rising-edge detector giving 1-cycle pulses tick and start_p.
REQ-015 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advances every clk, never reaches zero.
REQ-016 FSM states: IDLE, DELAY, MEASURE, RESULT, FOUL; all outputs registered.
REQ-017 IDLE/RESULT/FOUL: start_p -> DELAY; delay counter loads MIN_DELAY + LFSR value in that cycle (range 100..355); bcd clears to 000; done/false_start/overflow clear.
REQ-018 DELAY: counter decrements by 1 per tick; synchronized react high -> FOUL (takes priority over tick); counter at 1 with tick -> MEASURE.
REQ-019 MEASURE: led_go=1; bcd increments by 1 per tick with decimal carry (009->010, 099->100); react high -> RESULT, done=1.
REQ-020 MEASURE, react and tick same cycle: react wins, no increment.
REQ-021 MEASURE, tick while bcd=999: bcd stays 999, overflow=1, done=1, -> RESULT.
REQ-022 RESULT holds bcd until next start_p; FOUL holds bcd=000, false_start=1, until next start_p.
REQ-023 start_p in DELAY or MEASURE is ignored.
REQ-024 Latency: react edge at input pin to led_go low / done high <= 3 clk cycles.
REQ-025 led_go=0 in every state except MEASURE; busy=1 exactly in DELAY and MEASURE.

Reset
REQ-026 rst high at a clk edge: state=IDLE, bcd=12'h000, led_go/busy/done/false_start/overflow=0, LFSR=LFSR_SEED, synchronizer and edge flops=0, delay counter=0.
REQ-027 rst mid-operation (any state) aborts the trial; outputs reach reset values one cycle after the sampling edge; no tick or start is acted on while rst high.

Structure
REQ-028 Package reaction_pkg holds the state enumeration, BCD digit width (4), counter width, and default MIN_DELAY/LFSR_SEED constants.
REQ-029 One sub-module, bcd_counter3: synchronous clear, increment enable, 3-digit BCD output, saturate-at-999 flag.
REQ-030 Synchronizers and edge detectors are inlined in reaction_timer.

Verification (bench drives div_clk with short period for speed)
REQ-031 Reset: assert rst 2 cycles -> bcd=000, led_go=0, busy=0, done=0, false_start=0, overflow=0.
REQ-032 Normal trial: start pulse, wait until led_go=1 after MIN_DELAY+LFSR ticks (check against reference model LFSR), react after 37 ticks -> bcd=12'h037, done=1, led_go=0, busy=0.
REQ-033 False start: react during DELAY -> false_start=1 within 3 cycles, led_go never rises, bcd=000; next start clears false_start.
REQ-034 Saturation/carry: no react in MEASURE -> bcd passes 009->010 and 099->100, ends 12'h999 with overflow=1, done=1.
REQ-035 Simultaneous: at bcd=042 assert react in the cycle tick pulses -> final bcd=12'h042.
REQ-036 Abort/ignore: start pulse during MEASURE -> no effect; rst during MEASURE at bcd=015 -> all outputs at reset values next cycle, state IDLE.
